// File: rtl/ps2_keyboard_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Also holds the frame parity helper used by the frame evaluation logic.
package ps2_keyboard_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_REL = 8'hF0;

  localparam int FILT_DEFAULT    = 8;
  localparam int TIMEOUT_DEFAULT = 50000;

  // PS/2 uses odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic frame_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_keyboard_if.sv
// Bundle of the PS/2 line inputs and the decoded key-event outputs.
// The receiver uses the master view; a key-event consumer uses the slave view.
interface ps2_keyboard_if;

  logic       ps2_clk;
  logic       ps2_dat;
  logic       kdone;
  logic [7:0] kdata;
  logic       krelease;
  logic       kext;
  logic       kerr;

  modport master (
    input  ps2_clk,
    input  ps2_dat,
    output kdone,
    output kdata,
    output krelease,
    output kext,
    output kerr
  );

  modport slave (
    input ps2_clk,
    input ps2_dat,
    input kdone,
    input kdata,
    input krelease,
    input kext,
    input kerr
  );

endinterface

// File: rtl/ps2_keyboard_filter.sv
// Two-flop synchronizer plus deglitcher for the PS/2 clock line.
// The filtered level only moves after FILT consecutive samples disagree with it.
module ps2_filter
  import ps2_keyboard_pkg::*;
#(
  parameter int FILT = FILT_DEFAULT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic fall
);

  localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT - 1);

  logic          meta_r;
  logic          sync_r;
  logic          level_r;
  logic [CW-1:0] cnt_r;
  logic          fall_r;

  // Synchronize, count disagreeing samples, flip the level and flag a falling edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      meta_r  <= 1'b1;
      sync_r  <= 1'b1;
      level_r <= 1'b1;
      cnt_r   <= '0;
      fall_r  <= 1'b0;
    end else begin
      meta_r <= raw;
      sync_r <= meta_r;
      fall_r <= 1'b0;
      if (sync_r == level_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
        level_r <= sync_r;
        cnt_r   <= '0;
        fall_r  <= ~sync_r;
      end else begin
        cnt_r <= cnt_r + CW'(1'b1);
      end
    end
  end

  assign fall = fall_r;

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: frames bits on filtered clock falls, strips E0/F0 prefixes
// and presents one strobed scan code per key event, or an error strobe.
module ps2_keyboard
  import ps2_keyboard_pkg::*;
#(
  parameter int FILT    = FILT_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic           clock,
  input  logic           reset_n,
  ps2_keyboard_if.master kbd
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT);

  logic          fall_s;
  logic          dat_meta_r;
  logic          dat_sync_r;
  ps2_state_e    state_r;
  ps2_state_e    next_state_s;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic          parity_r;
  logic [TW-1:0] timeout_r;
  logic          ext_pend_r;
  logic          ext_pend_s;
  logic          rel_pend_r;
  logic          rel_pend_s;
  logic          kdone_r;
  logic          kdone_s;
  logic          kerr_r;
  logic          kerr_s;
  logic [7:0]    kdata_r;
  logic [7:0]    kdata_s;
  logic          krelease_r;
  logic          krelease_s;
  logic          kext_r;
  logic          kext_s;
  logic          abort_s;
  logic          frame_done_s;
  logic          frame_good_s;

  ps2_filter #(.FILT(FILT)) u_clk_filter (
    .clock   (clock),
    .reset_n (reset_n),
    .raw     (kbd.ps2_clk),
    .fall    (fall_s)
  );

  // Data line only needs synchronizing; it is stable while the filtered clock settles.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      dat_meta_r <= 1'b1;
      dat_sync_r <= 1'b1;
    end else begin
      dat_meta_r <= kbd.ps2_dat;
      dat_sync_r <= dat_meta_r;
    end
  end

  assign abort_s      = (state_r != IDLE) && (timeout_r == TIMEOUT_V);
  assign frame_done_s = fall_s && (state_r == STOP);
  assign frame_good_s = frame_parity_ok(shift_r, parity_r) && dat_sync_r;

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; a timeout overrides any edge arriving in the same cycle.
  always_comb begin
    next_state_s = state_r;
    if (abort_s) begin
      next_state_s = IDLE;
    end else if (fall_s) begin
      case (state_r)
        IDLE:    next_state_s = dat_sync_r ? IDLE : DATA;
        DATA:    next_state_s = (bit_cnt_r == 3'd7) ? PARITY : DATA;
        PARITY:  next_state_s = STOP;
        STOP:    next_state_s = IDLE;
        default: next_state_s = IDLE;
      endcase
    end else begin
      next_state_s = state_r;
    end
  end

  // Bit counter, shift register, parity capture and inactivity timer.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      parity_r  <= 1'b0;
      timeout_r <= '0;
    end else begin
      if (fall_s || (state_r == IDLE) || abort_s) begin
        timeout_r <= '0;
      end else begin
        timeout_r <= timeout_r + TW'(1'b1);
      end
      if (fall_s && !abort_s) begin
        case (state_r)
          IDLE: bit_cnt_r <= 3'd0;
          DATA: begin
            shift_r   <= {dat_sync_r, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
          end
          PARITY:  parity_r <= dat_sync_r;
          STOP:    bit_cnt_r <= 3'd0;
          default: bit_cnt_r <= 3'd0;
        endcase
      end
    end
  end

  // Output decode: prefixes arm pend flags, codes strobe kdone, errors strobe kerr.
  always_comb begin
    kdone_s    = 1'b0;
    kerr_s     = 1'b0;
    kdata_s    = kdata_r;
    krelease_s = krelease_r;
    kext_s     = kext_r;
    ext_pend_s = ext_pend_r;
    rel_pend_s = rel_pend_r;
    if (abort_s) begin
      kerr_s     = 1'b1;
      ext_pend_s = 1'b0;
      rel_pend_s = 1'b0;
    end else if (frame_done_s) begin
      if (!frame_good_s) begin
        kerr_s     = 1'b1;
        ext_pend_s = 1'b0;
        rel_pend_s = 1'b0;
      end else if (shift_r == PS2_EXT) begin
        ext_pend_s = 1'b1;
      end else if (shift_r == PS2_REL) begin
        rel_pend_s = 1'b1;
      end else begin
        kdone_s    = 1'b1;
        kdata_s    = shift_r;
        krelease_s = rel_pend_r;
        kext_s     = ext_pend_r;
        ext_pend_s = 1'b0;
        rel_pend_s = 1'b0;
      end
    end else begin
      kdone_s = 1'b0;
    end
  end

  // Registered outputs and pend flags.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      kdone_r    <= 1'b0;
      kerr_r     <= 1'b0;
      kdata_r    <= 8'h00;
      krelease_r <= 1'b0;
      kext_r     <= 1'b0;
      ext_pend_r <= 1'b0;
      rel_pend_r <= 1'b0;
    end else begin
      kdone_r    <= kdone_s;
      kerr_r     <= kerr_s;
      kdata_r    <= kdata_s;
      krelease_r <= krelease_s;
      kext_r     <= kext_s;
      ext_pend_r <= ext_pend_s;
      rel_pend_r <= rel_pend_s;
    end
  end

  assign kbd.kdone    = kdone_r;
  assign kbd.kerr     = kerr_r;
  assign kbd.kdata    = kdata_r;
  assign kbd.krelease = krelease_r;
  assign kbd.kext     = kext_r;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: drives PS/2 frames bit by bit and checks the
// strobed key events, error strobes, timeout, deglitching and mid-frame reset.
module tb_ps2_keyboard;
  import ps2_keyboard_pkg::*;

  localparam int FILT_TB    = 4;
  localparam int TIMEOUT_TB = 600;
  localparam int HALF       = 40;

  logic clock;
  logic reset_n;
  int   checks_cnt;
  int   errors_cnt;
  int   done_cnt;
  int   err_cnt;
  int   both_cnt;
  int   d0;
  int   e0;

  ps2_keyboard_if kb ();

  ps2_keyboard #(.FILT(FILT_TB), .TIMEOUT(TIMEOUT_TB)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .kbd     (kb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count strobes away from the active edge.
  always @(negedge clock) begin
    if (kb.kdone) done_cnt++;
    if (kb.kerr) err_cnt++;
    if (kb.kdone && kb.kerr) both_cnt++;
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      kb.ps2_dat = bits[i];
      tick(HALF);
      kb.ps2_clk = 1'b0;
      tick(HALF);
      kb.ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par_flip, input logic stop);
    logic par;
    par = (~^data) ^ par_flip;
    send_bits({stop, par, data, 1'b0}, 11);
    kb.ps2_dat = 1'b1;
    tick(HALF);
  endtask

  task automatic snap();
    d0 = done_cnt;
    e0 = err_cnt;
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    done_cnt   = 0;
    err_cnt    = 0;
    both_cnt   = 0;
    kb.ps2_clk = 1'b1;
    kb.ps2_dat = 1'b1;
    reset_n    = 1'b0;
    tick(5);
    reset_n = 1'b1;
    tick(5);

    check_value("rst_kdone", {31'd0, kb.kdone}, 32'd0);
    check_value("rst_kerr", {31'd0, kb.kerr}, 32'd0);
    check_value("rst_kdata", {24'd0, kb.kdata}, 32'h00);
    check_value("rst_krelease", {31'd0, kb.krelease}, 32'd0);
    check_value("rst_kext", {31'd0, kb.kext}, 32'd0);
    check_value("rst_state", {30'd0, dut.state_r}, {30'd0, IDLE});

    // Plain make code
    snap();
    send_frame(8'h1C, 1'b0, 1'b1);
    check_value("make_done", done_cnt - d0, 32'd1);
    check_value("make_err", err_cnt - e0, 32'd0);
    check_value("make_data", {24'd0, kb.kdata}, 32'h1C);
    check_value("make_rel", {31'd0, kb.krelease}, 32'd0);
    check_value("make_ext", {31'd0, kb.kext}, 32'd0);

    // Release: F0 1C
    snap();
    send_frame(8'hF0, 1'b0, 1'b1);
    check_value("f0_nodone", done_cnt - d0, 32'd0);
    send_frame(8'h1C, 1'b0, 1'b1);
    check_value("brk_done", done_cnt - d0, 32'd1);
    check_value("brk_data", {24'd0, kb.kdata}, 32'h1C);
    check_value("brk_rel", {31'd0, kb.krelease}, 32'd1);
    check_value("brk_ext", {31'd0, kb.kext}, 32'd0);

    // Extended release: E0 F0 75, then 1C clean
    snap();
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    check_value("e0f0_nodone", done_cnt - d0, 32'd0);
    send_frame(8'h75, 1'b0, 1'b1);
    check_value("ext_done", done_cnt - d0, 32'd1);
    check_value("ext_data", {24'd0, kb.kdata}, 32'h75);
    check_value("ext_ext", {31'd0, kb.kext}, 32'd1);
    check_value("ext_rel", {31'd0, kb.krelease}, 32'd1);
    send_frame(8'h1C, 1'b0, 1'b1);
    check_value("after_ext", {30'd0, kb.kext, kb.krelease}, 32'd0);

    // Repeated prefix E0 E0 74
    snap();
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h74, 1'b0, 1'b1);
    check_value("rep_done", done_cnt - d0, 32'd1);
    check_value("rep_flags", {30'd0, kb.kext, kb.krelease}, 32'd2);
    check_value("rep_data", {24'd0, kb.kdata}, 32'h74);

    // Parity error after F0 clears the pending release
    snap();
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b1, 1'b1);
    check_value("par_err", err_cnt - e0, 32'd1);
    check_value("par_nodone", done_cnt - d0, 32'd0);
    check_value("par_data", {24'd0, kb.kdata}, 32'h74);
    send_frame(8'h1C, 1'b0, 1'b1);
    check_value("par_next_rel", {31'd0, kb.krelease}, 32'd0);
    check_value("par_next_data", {24'd0, kb.kdata}, 32'h1C);

    // Stop-bit error
    snap();
    send_frame(8'h29, 1'b0, 1'b0);
    check_value("stop_err", err_cnt - e0, 32'd1);
    check_value("stop_nodone", done_cnt - d0, 32'd0);
    check_value("stop_data", {24'd0, kb.kdata}, 32'h1C);

    // Timeout: start bit plus 4 data bits, then silence
    snap();
    send_bits({3'b110, 8'h29, 1'b0}, 5);
    kb.ps2_dat = 1'b1;
    check_value("to_in_data", {30'd0, dut.state_r}, {30'd0, DATA});
    tick(TIMEOUT_TB - 150);
    check_value("to_early", err_cnt - e0, 32'd0);
    tick(150);
    check_value("to_err", err_cnt - e0, 32'd1);
    check_value("to_idle", {30'd0, dut.state_r}, {30'd0, IDLE});
    check_value("to_nodone", done_cnt - d0, 32'd0);
    send_frame(8'h29, 1'b0, 1'b1);
    check_value("to_next_done", done_cnt - d0, 32'd1);
    check_value("to_next_data", {24'd0, kb.kdata}, 32'h29);

    // Glitches of FILT-1 cycles with data low must not start a frame
    snap();
    kb.ps2_dat = 1'b0;
    for (int g = 0; g < 3; g++) begin
      kb.ps2_clk = 1'b0;
      tick(FILT_TB - 1);
      kb.ps2_clk = 1'b1;
      tick(20);
    end
    kb.ps2_dat = 1'b1;
    check_value("glitch_state", {30'd0, dut.state_r}, {30'd0, IDLE});
    send_frame(8'h1C, 1'b0, 1'b1);
    check_value("glitch_done", done_cnt - d0, 32'd1);
    check_value("glitch_data", {24'd0, kb.kdata}, 32'h1C);

    // Reset in the middle of DATA
    snap();
    send_frame(8'hE0, 1'b0, 1'b1);
    send_bits({3'b110, 8'h75, 1'b0}, 4);
    kb.ps2_dat = 1'b1;
    reset_n = 1'b0;
    tick(3);
    check_value("mid_rst_outs", {22'd0, kb.kdata, kb.kdone, kb.kerr}, 32'd0);
    check_value("mid_rst_flags", {30'd0, kb.kext, kb.krelease}, 32'd0);
    reset_n = 1'b1;
    tick(5);
    check_value("mid_rst_state", {30'd0, dut.state_r}, {30'd0, IDLE});
    check_value("mid_rst_nostrobe", (done_cnt - d0) + (err_cnt - e0), 32'd0);
    send_frame(8'h75, 1'b0, 1'b1);
    check_value("post_rst_done", done_cnt - d0, 32'd1);
    check_value("post_rst_data", {24'd0, kb.kdata}, 32'h75);
    check_value("post_rst_ext", {31'd0, kb.kext}, 32'd0);

    check_value("done_err_overlap", both_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard.md
PS2_KEYBOARD -- requirements
Module: ps2_keyboard

Interface
REQ-001 Parameter FILT, default 8: consecutive equal samples required before the filtered ps2_clk changes level.
REQ-002 Parameter TIMEOUT, default 50000: clock cycles without a filtered falling edge before a partial frame is abandoned.
REQ-003 clock  input  1  system clock; all logic on posedge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 ps2_clk  input  1  PS/2 clock line, asynchronous, device-driven.
REQ-006 ps2_dat  input  1  PS/2 data line, asynchronous, device-driven.
REQ-007 kdone  output  1  one-cycle strobe: new scan code valid on kdata/krelease/kext.
REQ-008 kdata  output  8  last decoded scan code, prefixes stripped; held until the next kdone.
REQ-009 krelease  output  1  the code was preceded by F0 (key release); qualified by kdone, held.
REQ-010 kext  output  1  the code was preceded by E0 (extended key); qualified by kdone, held.
REQ-011 kerr  output  1  one-cycle strobe on a parity, stop-bit or timeout error.

Function
REQ-012 Each of ps2_clk and ps2_dat SHALL pass a 2-flop synchronizer; ps2_clk SHALL additionally be deglitched: the filtered level changes only after FILT consecutive equal synchronized samples.
REQ-013 A bit SHALL be sampled from synchronized ps2_dat in the cycle the filtered ps2_clk falls (1 -> 0).
REQ-014 FSM states: IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: on a falling edge, sampled bit 0 -> DATA with bit count 0; sampled bit 1 -> stay in IDLE, no strobe.
REQ-016 DATA: each falling edge shifts the bit into the shift register LSB-first; after the 8th bit -> PARITY.
REQ-017 PARITY: the falling edge captures the parity bit; -> STOP.
REQ-018 STOP: the falling edge captures the stop bit; -> IDLE, and the frame is evaluated.
REQ-019 A frame SHALL be good only when the XOR of the 8 data bits and the parity bit is 1 (odd) and the stop bit is 1.
REQ-020 Good byte E0: set ext_pend; no kdone.
REQ-021 Good byte F0: set rel_pend; no kdone.
REQ-022 Any other good byte: in the cycle after the stop edge, SHALL drive kdone=1 for exactly one cycle with kdata=byte, krelease=rel_pend and kext=ext_pend, then clear both pend flags.
REQ-023 Bad frame: kerr=1 for one cycle, in the cycle after the stop edge; byte discarded; both pend flags cleared; kdata unchanged.
REQ-024 A timeout counter SHALL clear on every falling edge and count only outside IDLE.
REQ-025 When the timeout counter reaches TIMEOUT: -> IDLE, kerr one cycle, pend flags cleared, no kdone.
REQ-026 Sequence E0 F0 xx SHALL produce one kdone with kext=1, krelease=1; a repeated prefix SHALL be idempotent.
REQ-027 kdone and kerr SHALL never be asserted in the same cycle.
REQ-028 Minimum spacing between two kdone strobes is one full frame; the receiver has no buffer, and the consumer samples on kdone.

Reset
REQ-029 On reset_n=0, at the next clock edge: FSM=IDLE, bit count=0, shift register=0, timeout=0, pend flags=0, kdone=0, kerr=0, kdata=8'h00, krelease=0, kext=0, filter state=idle-high (1).
REQ-030 Reset mid-frame SHALL discard the partial frame with no strobe; reception resumes at the next start bit after release.

Structure
REQ-031 The shared package SHALL hold: the FSM state enum, the constants PS2_EXT=8'hE0 and PS2_REL=8'hF0, and the default values of FILT and TIMEOUT.
REQ-032 Synchronizer plus deglitcher SHALL be one sub-module, ps2_filter, instanced for ps2_clk, with a falling-edge strobe output.

Verification
REQ-033 Frame 0x1C (A make: start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at a 12.5 kHz device clock -> one kdone, kdata=1C, krelease=0, kext=0.
REQ-034 Frames F0, 1C -> a single kdone after the second frame: kdata=1C, krelease=1, kext=0; no strobe after F0.
REQ-035 Frames E0, F0, 75 -> one kdone: kdata=75, kext=1, krelease=1; the next frame 1C -> kext=0, krelease=0.
REQ-036 Frame 0x1C with parity bit 1 -> kerr pulse, no kdone, kdata keeps its previous value; a pending F0 is cleared.
REQ-037 Device stops after 4 data bits, then idles TIMEOUT cycles -> kerr at cycle TIMEOUT, FSM=IDLE; the next full frame 0x29 -> kdone, kdata=29.
REQ-038 Glitch pulses on ps2_clk of FILT-1 cycles -> no bit sampled, FSM unchanged; reset_n=0 in the middle of DATA -> all outputs at reset values, no strobes.
